// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXIS master port between NUM_S AXIS slaves.
// A grant is held until the packet ends (tlast or beat limit); the data path
// is combinational while granted and each grant costs one idle cycle.
module axis_rr_arbiter #(
    parameter int unsigned NUM_S              = 4,
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned TLAST_EN           = 1,
    parameter int unsigned TSTRB_EN           = 0,
    parameter int unsigned MAX_BEATS          = 0,
    parameter int unsigned IDX_W              = $clog2(NUM_S)
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_areset,
    input  logic [NUM_S-1:0]                      s00_axis_tvalid,
    output logic [NUM_S-1:0]                      s00_axis_tready,
    input  logic [NUM_S-1:0]                      s00_axis_tlast,
    input  logic [NUM_S*C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [NUM_S*C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0]         m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]       m00_axis_tstrb,
    output logic                                  grant_valid,
    output logic [IDX_W-1:0]                      grant_idx
);

    localparam int unsigned DW    = C_AXIS_TDATA_WIDTH;
    localparam int unsigned SW    = C_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned CNT_W = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_S - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             grant_valid_q, grant_valid_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             g_valid;
    logic             g_last;
    logic [DW-1:0]    g_data;
    logic [SW-1:0]    g_strb;
    logic             granted;
    logic             xfer;
    logic             end_beat;

    // Search requesters starting just after the last granted index
    always_comb begin
        int unsigned cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = last_idx_q;
        for (int unsigned k = 1; k <= NUM_S; k++) begin
            cand = (32'(last_idx_q) + k) % NUM_S;
            if (!pick_found && s00_axis_tvalid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Select the granted slave's signals and steer master ready back to it
    always_comb begin
        g_valid         = 1'b0;
        g_last          = 1'b0;
        g_data          = '0;
        g_strb          = '0;
        s00_axis_tready = '0;
        for (int unsigned i = 0; i < NUM_S; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                g_valid            = s00_axis_tvalid[i];
                g_last             = s00_axis_tlast[i];
                g_data             = s00_axis_tdata[i*DW +: DW];
                g_strb             = s00_axis_tstrb[i*SW +: SW];
                s00_axis_tready[i] = granted & m00_axis_tready;
            end
        end
    end

    assign granted  = (state_q == ST_GRANT);
    assign xfer     = granted & g_valid & m00_axis_tready;
    assign end_beat = xfer & (((TLAST_EN != 0) & g_last) |
                              ((MAX_BEATS != 0) & (beat_cnt_q == BEAT_LAST)));

    // Master port: valid depends only on state and slave valid
    assign m00_axis_tvalid = granted & g_valid;
    assign m00_axis_tdata  = g_data;
    assign m00_axis_tstrb  = (TSTRB_EN != 0) ? g_strb : '1;
    assign m00_axis_tlast  = (TLAST_EN != 0) & g_last;
    assign grant_valid     = grant_valid_q;
    assign grant_idx       = grant_idx_q;

    // Next-state: arbitrate in IDLE, count beats and release in GRANT
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d     = ST_GRANT;
                    grant_idx_d = pick_idx;
                    last_idx_d  = pick_idx;
                    beat_cnt_d  = '0;
                end
            end
            ST_GRANT: begin
                if (xfer && (beat_cnt_q != CNT_MAX)) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (end_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        grant_valid_d = (state_d == ST_GRANT);
    end

    // State and pointer registers
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q       <= ST_IDLE;
            grant_idx_q   <= '0;
            last_idx_q    <= LAST_RST;
            beat_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            last_idx_q    <= last_idx_d;
            beat_cnt_q    <= beat_cnt_d;
            grant_valid_q <= grant_valid_d;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: two instances (tlast-terminated and beat-limited)
// checked every cycle against a behavioural round-robin model, plus literal
// expectations for reset, a single packet, rotation order and async reset.
module tb_axis_rr_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    // Per-instance configuration: [0] default, [1] TLAST_EN=0 MAX_BEATS=4 TSTRB_EN=1
    localparam int TLE [2] = '{1, 0};
    localparam int MB  [2] = '{0, 4};
    localparam int TSE [2] = '{0, 1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NS-1:0]    s_tvalid [2];
    logic [NS-1:0]    s_tready [2];
    logic [NS-1:0]    s_tlast  [2];
    logic [NS*DW-1:0] s_tdata  [2];
    logic [NS*SW-1:0] s_tstrb  [2];
    logic             m_tvalid [2];
    logic             m_tready [2];
    logic             m_tlast  [2];
    logic [DW-1:0]    m_tdata  [2];
    logic [SW-1:0]    m_tstrb  [2];
    logic             gv       [2];
    logic [1:0]       gidx_o   [2];

    axis_rr_arbiter #(
        .NUM_S(NS), .C_AXIS_TDATA_WIDTH(DW), .TLAST_EN(1), .TSTRB_EN(0), .MAX_BEATS(0)
    ) dut_a (
        .axis_aclk(clk), .axis_areset(rst),
        .s00_axis_tvalid(s_tvalid[0]), .s00_axis_tready(s_tready[0]),
        .s00_axis_tlast(s_tlast[0]), .s00_axis_tdata(s_tdata[0]), .s00_axis_tstrb(s_tstrb[0]),
        .m00_axis_tvalid(m_tvalid[0]), .m00_axis_tready(m_tready[0]),
        .m00_axis_tlast(m_tlast[0]), .m00_axis_tdata(m_tdata[0]), .m00_axis_tstrb(m_tstrb[0]),
        .grant_valid(gv[0]), .grant_idx(gidx_o[0])
    );

    axis_rr_arbiter #(
        .NUM_S(NS), .C_AXIS_TDATA_WIDTH(DW), .TLAST_EN(0), .TSTRB_EN(1), .MAX_BEATS(4)
    ) dut_b (
        .axis_aclk(clk), .axis_areset(rst),
        .s00_axis_tvalid(s_tvalid[1]), .s00_axis_tready(s_tready[1]),
        .s00_axis_tlast(s_tlast[1]), .s00_axis_tdata(s_tdata[1]), .s00_axis_tstrb(s_tstrb[1]),
        .m00_axis_tvalid(m_tvalid[1]), .m00_axis_tready(m_tready[1]),
        .m00_axis_tlast(m_tlast[1]), .m00_axis_tdata(m_tdata[1]), .m00_axis_tstrb(m_tstrb[1]),
        .grant_valid(gv[1]), .grant_idx(gidx_o[1])
    );

    int checks = 0;
    int errors = 0;

    // Model state: is a grant held, who holds it, who was granted last, beats so far
    int busy [2], gidx [2], lastp [2], beats [2];
    int n_busy [2], n_gidx [2], n_lastp [2], n_beats [2];
    logic [NS-1:0] acc [2];

    task automatic chk(input string name, input int d, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            busy[d]  = 0; gidx[d]  = 0; lastp[d]  = NS - 1; beats[d]  = 0;
            n_busy[d] = 0; n_gidx[d] = 0; n_lastp[d] = NS - 1; n_beats[d] = 0;
            acc[d] = '0;
        end
    endtask

    // Compare every output against the model, then work out the model's next state
    task automatic model_check();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic [NS-1:0] tv, tl, exp_tr;
            logic          exp_mv;
            int            g;
            tv = s_tvalid[d];
            tl = s_tlast[d];
            g  = gidx[d];
            exp_tr = '0;
            exp_mv = 1'b0;
            if (busy[d] != 0) begin
                exp_mv = tv[g];
                if (m_tready[d]) exp_tr[g] = 1'b1;
            end
            chk("m_tvalid", d, longint'(m_tvalid[d]), longint'(exp_mv));
            chk("s_tready", d, longint'(s_tready[d]), longint'(exp_tr));
            chk("grant_valid", d, longint'(gv[d]), longint'(busy[d] != 0));
            chk("grant_idx", d, longint'(gidx_o[d]), longint'(g));
            if (exp_mv) begin
                chk("m_tdata", d, longint'(m_tdata[d]), longint'(s_tdata[d][g*DW +: DW]));
                chk("m_tstrb", d, longint'(m_tstrb[d]),
                    (TSE[d] != 0) ? longint'(s_tstrb[d][g*SW +: SW]) : longint'(4'hF));
                chk("m_tlast", d, longint'(m_tlast[d]), (TLE[d] != 0) ? longint'(tl[g]) : 64'd0);
            end
            acc[d] = exp_tr & tv;
            n_busy[d] = busy[d]; n_gidx[d] = gidx[d]; n_lastp[d] = lastp[d]; n_beats[d] = beats[d];
            if (busy[d] == 0) begin
                bit found;
                found = 1'b0;
                for (int k = 1; k <= NS; k++) begin
                    int c;
                    c = (lastp[d] + k) % NS;
                    if (!found && tv[c]) begin
                        found = 1'b1;
                        n_busy[d] = 1; n_gidx[d] = c; n_lastp[d] = c; n_beats[d] = 0;
                    end
                end
            end else if (acc[d] != 0) begin
                n_beats[d] = beats[d] + 1;
                if ((TLE[d] != 0 && tl[g]) || (MB[d] != 0 && beats[d] == MB[d] - 1))
                    n_busy[d] = 0;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            busy[d] = n_busy[d]; gidx[d] = n_gidx[d]; lastp[d] = n_lastp[d]; beats[d] = n_beats[d];
        end
    endtask

    // AXIS-compliant random sources: a beat is held until accepted
    task automatic gen();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NS; i++) begin
                if (!s_tvalid[d][i] || acc[d][i]) begin
                    s_tvalid[d][i]          = ($urandom % 4) != 0;
                    s_tlast[d][i]           = ($urandom % 4) == 0;
                    s_tdata[d][i*DW +: DW]  = $urandom;
                    s_tstrb[d][i*SW +: SW]  = SW'($urandom);
                end
            end
            m_tready[d] = ($urandom % 10) < 7;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_tvalid[d] = '0; s_tlast[d] = '0; s_tdata[d] = '0; s_tstrb[d] = '0;
            m_tready[d] = 1'b1;
        end
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_m_tvalid", d, longint'(m_tvalid[d]), 0);
            chk("rst_s_tready", d, longint'(s_tready[d]), 0);
            chk("rst_grant_valid", d, longint'(gv[d]), 0);
            chk("rst_grant_idx", d, longint'(gidx_o[d]), 0);
        end

        // Slave 2 alone, 3-beat packet A0..A2
        s_tvalid[0] = 4'b0100;
        s_tdata[0][2*DW +: DW] = 32'hA0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        model_check();
        chk("p1_idle_gv", 0, longint'(gv[0]), 0);
        chk("p1_idle_mv", 0, longint'(m_tvalid[0]), 0);
        adv();
        for (int b = 0; b < 3; b++) begin
            s_tdata[0][2*DW +: DW] = 32'hA0 + 32'(b);
            s_tlast[0][2] = (b == 2);
            model_check();
            chk("p1_idx", 0, longint'(gidx_o[0]), 2);
            chk("p1_mv", 0, longint'(m_tvalid[0]), 1);
            chk("p1_data", 0, longint'(m_tdata[0]), longint'(32'hA0 + 32'(b)));
            chk("p1_tready", 0, longint'(s_tready[0]), 4'b0100);
            adv();
        end
        s_tvalid[0] = '0;
        s_tlast[0] = '0;
        model_check();
        chk("p1_end_gv", 0, longint'(gv[0]), 0);
        adv();

        // Slave 3 mid-packet, then asynchronous reset
        s_tvalid[0] = 4'b1000;
        s_tdata[0][3*DW +: DW] = 32'h33;
        model_check();
        adv();
        model_check();
        chk("p6_idx", 0, longint'(gidx_o[0]), 3);
        chk("p6_mv", 0, longint'(m_tvalid[0]), 1);
        adv();
        rst = 1'b1;
        #1;
        chk("p6_async_mv", 0, longint'(m_tvalid[0]), 0);
        chk("p6_async_tready", 0, longint'(s_tready[0]), 0);
        chk("p6_async_gv", 0, longint'(gv[0]), 0);
        model_reset();

        // All slaves with 1-beat packets on dut0; slaves 1,2 streaming on dut1
        s_tvalid[0] = 4'b1111; s_tlast[0] = 4'b1111;
        s_tvalid[1] = 4'b0110; s_tlast[1] = 4'b0110;
        for (int i = 0; i < NS; i++) begin
            s_tdata[0][i*DW +: DW] = 32'h100 + 32'(i);
            s_tdata[1][i*DW +: DW] = 32'h200 + 32'(i);
            s_tstrb[1][i*SW +: SW] = SW'(i + 3);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            model_check();
            if (c % 2 == 0) chk("rot_idle", 0, longint'(gv[0]), 0);
            else            chk("rot_idx", 0, longint'(gidx_o[0]), ((c - 1) / 2) % 4);
            if (c % 5 == 0) chk("lim_idle", 1, longint'(gv[1]), 0);
            else            chk("lim_idx", 1, longint'(gidx_o[1]), ((c / 5) % 2 == 0) ? 1 : 2);
            adv();
        end

        // Randomized traffic with backpressure and valid gaps
        for (int c = 0; c < 3000; c++) begin
            gen();
            model_check();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
